// File: rtl/project_pkg.sv
// Shared constants and state encodings for the push-button conditioning path.
// Also carries the polarity helper so every channel normalises pins the same way.
package project_pkg;

  // 10 ms of stability at a 50 MHz system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;

  localparam logic BTN_RELEASED = 1'b0;
  localparam logic BTN_PRESSED  = 1'b1;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } debounce_state_e;

  function automatic logic apply_polarity(input logic pin, input bit active_low);
    return active_low ? ~pin : pin;
  endfunction

endpackage

// File: rtl/project_debounce_bit.sv
// One button channel: polarity fix, two-flop synchroniser, stability counter
// and registered press/release strobes.
module project_debounce_bit
  import project_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw;
  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Observable FSM state; derived from the synchronised level vs. accepted level.
  debounce_state_e  state;

  logic             stable_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;
  logic             release_nxt;

  assign raw = apply_polarity(key_in, ACTIVE_LOW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= BTN_RELEASED;
      s2 <= BTN_RELEASED;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable        <= BTN_RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      stable        <= stable_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state       = (s2 == stable) ? ST_STABLE : ST_CHANGING;
    stable_nxt  = stable;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_STABLE: begin
        // A bounce that returned to the accepted level drops its count here.
        cnt_nxt = '0;
      end
      ST_CHANGING: begin
        if (cnt == CNT_LAST) begin
          stable_nxt  = s2;
          cnt_nxt     = '0;
          press_nxt   = (s2 == BTN_PRESSED);
          release_nxt = (s2 == BTN_RELEASED);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  assign btn_out = stable;

endmodule

// File: rtl/project_button_debounce.sv
// Debounces WIDTH raw board buttons into an active-high level vector for the
// PIO in_port, plus per-bit press/release strobes for edge capture.
module project_button_debounce
  import project_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    project_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_in        (key_in[i]),
      .btn_out       (btn_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: doc/project_button_debounce.md
# project_button_debounce

Input conditioning stage directly upstream of the button PIO slave: takes the raw push-button pins from the board, synchronises each one into `clk`, and debounces it with a per-bit stability counter. It normalises polarity to active-high. The debounced level vector drives the PIO `in_port`. One-cycle press and release strobes are provided for the interrupt/edge-capture logic.

## Interface
Parameters:
- `WIDTH`, 4, number of button channels.
- `DEBOUNCE_CYCLES`, 500000, consecutive clock cycles a new level must persist before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `ACTIVE_LOW`, 1, 1 = pressed pin reads 0 (board KEYs), 0 = pressed pin reads 1.

Ports:
- `clk` input 1: single system clock (Avalon clock).
- `reset_n` input 1: asynchronous active-low reset; asserted asynchronously, released synchronously by the system reset controller.
- `key_in` input WIDTH: raw asynchronous button pins.
- `btn_out` output WIDTH: debounced level, 1 = pressed. Connects to PIO `in_port`.
- `press_pulse` output WIDTH: one-cycle strobe when a bit's `btn_out` goes 0→1.
- `release_pulse` output WIDTH: one-cycle strobe when a bit's `btn_out` goes 1→0.

## Operation
- Each bit is fully independent and uses identical logic.
- Polarity: `raw = ACTIVE_LOW ? ~key_in[i] : key_in[i]`. This inversion is combinational, ahead of the synchroniser.
- Synchroniser: two flops, `s1 <= raw; s2 <= s1`. Reset value is 0 (released). Only `s2` is used downstream.
- Per-bit state `stable` (drives `btn_out`), with two states:
  - STABLE: `s2 == stable`. `cnt` is held at 0.
  - CHANGING: `s2 != stable`. `cnt` increments by 1 each cycle.
  - If `s2` returns to `stable` before the count completes, the bit goes back to STABLE and `cnt` clears to 0 on that edge. The pending change is discarded.
  - On the edge where `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`:
    - `stable <= s2` and `cnt <= 0`.
    - The matching pulse is registered high for exactly that next cycle.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- `press_pulse` and `release_pulse` are registered outputs and are mutually exclusive per bit. Pulses on different bits may coincide.
- Reset values: `s1`, `s2`, `stable`, `cnt`, `btn_out`, `press_pulse`, `release_pulse` are all 0.
  - A button held down through reset therefore produces a press after the normal latency following reset release.
- Reset mid-count clears all state immediately and asynchronously. No pulse is emitted for the aborted change.

## Timing
- Latency: raw pin change sampled at edge k → `s2` valid after edge k+1 → `btn_out` and pulse change after edge k+1+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+2 clocks.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s2` produces no output change.
- Pulse width is exactly 1 clock. The minimum spacing between press and release on one bit is DEBOUNCE_CYCLES clocks.
- All outputs are flop outputs, with no combinational path from `key_in`.
- The PIO adds 1 further cycle when registering `readdata`. That cycle is outside this block.

## Structure
- Shared package/include `project_pkg` holds:
  - the default `DEBOUNCE_CYCLES` for 50 MHz;
  - `BTN_RELEASED = 1'b0` and `BTN_PRESSED = 1'b1`;
  - the STABLE/CHANGING state encodings.
- Sub-module `project_debounce_bit`: synchroniser, counter and pulse logic for one channel. The top instantiates it WIDTH times in a generate loop and has no logic of its own.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `ACTIVE_LOW=1`.
- Reset: `reset_n=0` with `key_in=4'b0000` → all outputs 0. Release reset and hold `key_in=0` → `btn_out[3:0]` goes 1111 exactly 6 clocks after release, with `press_pulse=1111` for 1 clock.
- Clean press: `key_in[0]` 1→0 held → `btn_out[0]=1` after 6 edges, `press_pulse[0]` for 1 cycle, other bits unchanged. Then `key_in[0]` 0→1 → `release_pulse[0]` for 1 cycle, 6 edges later.
- Bounce rejection: toggle `key_in[1]` with low periods of 1, 2 and 3 cycles, then return high → `btn_out[1]` stays 0 and no pulse is emitted.
- Bounce then settle: 3-cycle low, 1-cycle high, then low held → counter restarts; `btn_out[1]=1` exactly 6 edges after the final falling sample.
- Simultaneous: `key_in` 1111→0101 in one cycle → `press_pulse=1010` on a single cycle; `btn_out=1010`.
- Reset mid-count: press `key_in[2]`, assert `reset_n` 3 cycles later, release it → no pulse during reset; press reported 6 clocks after release if still held.
